calc_req_arbiter: RTL and testbench

Parametrised multi-port request front-end for the calculator datapath. It generalises the fixed four-port, two-beat request protocol (command and operand 1 in the first cycle, operand 2 in the next) to NUM_PORTS ports and configurable widths. Each port captures its two-beat request into a per-port FIFO and rejects requests when that FIFO is full. A round-robin arbiter feeds a single downstream engine over a valid/ready handshake, carrying the tag and originating port id.

---
 rtl/calc_req_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_calc_req_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_req_arbiter.sv
// calc_req_arbiter
//   Multi-port request front-end for the calculator datapath. Each port sends a
//   two-beat request: command, tag and operand 1 in the first beat, operand 2
//   in the second. A finished request goes into that port's FIFO, or is rejected
//   when the FIFO is full. A round-robin arbiter then moves FIFO heads into a
//   single output register that drives the engine valid/ready handshake.
//
// Ports
//   clk, reset        clock (rising edge); asynchronous active-high reset
//   req_cmd_in        per-port command; cmd == 0 means no request
//   req_data_in       per-port operand (op1 in beat 1, op2 in beat 2)
//   req_tag_in        per-port tag, sampled in beat 1
//   rej_resp/rej_tag  per-port overflow response (2'b10), one cycle after the drop
//   eng_*             granted request toward the engine, with originating port
//   fifo_level        per-port registered FIFO occupancy
module calc_req_arbiter #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned CMD_W      = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TAG_W      = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned PortW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int unsigned LvlW      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
   input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
   input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
   output logic [NUM_PORTS*2-1:0]      rej_resp,
   output logic [NUM_PORTS*TAG_W-1:0]  rej_tag,
   output logic                        eng_valid,
   input  logic                        eng_ready,
   output logic [CMD_W-1:0]            eng_cmd,
   output logic [DATA_W-1:0]           eng_op1,
   output logic [DATA_W-1:0]           eng_op2,
   output logic [TAG_W-1:0]            eng_tag,
   output logic [PortW-1:0]            eng_port,
   output logic [NUM_PORTS*LvlW-1:0]   fifo_level
);

   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

   typedef enum logic {StIdle, StOp2} cap_st_e;

   // Capture stage
   cap_st_e           st_q      [NUM_PORTS];
   logic [CMD_W-1:0]  cap_cmd_q [NUM_PORTS];
   logic [DATA_W-1:0] cap_op1_q [NUM_PORTS];
   logic [TAG_W-1:0]  cap_tag_q [NUM_PORTS];

   // Per-port FIFOs
   logic [CMD_W-1:0]  mem_cmd_q [NUM_PORTS][FIFO_DEPTH];
   logic [DATA_W-1:0] mem_op1_q [NUM_PORTS][FIFO_DEPTH];
   logic [DATA_W-1:0] mem_op2_q [NUM_PORTS][FIFO_DEPTH];
   logic [TAG_W-1:0]  mem_tag_q [NUM_PORTS][FIFO_DEPTH];
   logic [AddrW-1:0]  wr_ptr_q  [NUM_PORTS];
   logic [AddrW-1:0]  rd_ptr_q  [NUM_PORTS];
   logic [LvlW-1:0]   level_q   [NUM_PORTS];

   logic [1:0]        rej_resp_q [NUM_PORTS];
   logic [TAG_W-1:0]  rej_tag_q  [NUM_PORTS];

   // Arbiter and output register
   logic [PortW-1:0]  rr_q, rr_d, win, idx;
   logic              found, load;
   logic [NUM_PORTS-1:0] push, push_ok, pop;

   logic              eng_valid_q;
   logic [CMD_W-1:0]  eng_cmd_q;
   logic [DATA_W-1:0] eng_op1_q, eng_op2_q;
   logic [TAG_W-1:0]  eng_tag_q;
   logic [PortW-1:0]  eng_port_q;

   always_comb begin
      push    = '0;
      push_ok = '0;
      pop     = '0;
      found   = 1'b0;
      win     = '0;
      idx     = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         push[p] = (st_q[p] == StOp2);
         // Registered level decides fullness; a same-edge pop does not free a slot.
         push_ok[p] = push[p] && (level_q[p] != LvlW'(FIFO_DEPTH));
      end
      // First non-empty FIFO at or after the round-robin pointer.
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = PortW'((32'(rr_q) + i) % NUM_PORTS);
         if (!found && (level_q[idx] != '0)) begin
            found = 1'b1;
            win   = idx;
         end
      end
      load = !eng_valid_q || eng_ready;
      rr_d = rr_q;
      if (load && found) begin
         pop[win] = 1'b1;
         rr_d     = PortW'((32'(win) + 32'd1) % NUM_PORTS);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q        <= '0;
         eng_valid_q <= 1'b0;
         eng_cmd_q   <= '0;
         eng_op1_q   <= '0;
         eng_op2_q   <= '0;
         eng_tag_q   <= '0;
         eng_port_q  <= '0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            st_q[p]       <= StIdle;
            cap_cmd_q[p]  <= '0;
            cap_op1_q[p]  <= '0;
            cap_tag_q[p]  <= '0;
            wr_ptr_q[p]   <= '0;
            rd_ptr_q[p]   <= '0;
            level_q[p]    <= '0;
            rej_resp_q[p] <= 2'b00;
            rej_tag_q[p]  <= '0;
         end
      end else begin
         rr_q <= rr_d;
         if (load) begin
            eng_valid_q <= found;
            if (found) begin
               eng_cmd_q  <= mem_cmd_q[win][rd_ptr_q[win]];
               eng_op1_q  <= mem_op1_q[win][rd_ptr_q[win]];
               eng_op2_q  <= mem_op2_q[win][rd_ptr_q[win]];
               eng_tag_q  <= mem_tag_q[win][rd_ptr_q[win]];
               eng_port_q <= win;
            end
         end
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            case (st_q[p])
               StIdle: begin
                  if (req_cmd_in[p*CMD_W +: CMD_W] != '0) begin
                     cap_cmd_q[p] <= req_cmd_in[p*CMD_W +: CMD_W];
                     cap_op1_q[p] <= req_data_in[p*DATA_W +: DATA_W];
                     cap_tag_q[p] <= req_tag_in[p*TAG_W +: TAG_W];
                     st_q[p]      <= StOp2;
                  end
               end
               // cmd is ignored in the operand-2 beat.
               StOp2:   st_q[p] <= StIdle;
               default: st_q[p] <= StIdle;
            endcase
            if (push_ok[p]) wr_ptr_q[p] <= wr_ptr_q[p] + 1'b1;
            if (pop[p])     rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
            level_q[p]    <= level_q[p] + LvlW'(push_ok[p]) - LvlW'(pop[p]);
            rej_resp_q[p] <= (push[p] && !push_ok[p]) ? 2'b10 : 2'b00;
            rej_tag_q[p]  <= (push[p] && !push_ok[p]) ? cap_tag_q[p] : '0;
         end
      end
   end

   // FIFO storage needs no reset; pointers and levels define validity.
   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (push_ok[p]) begin
            mem_cmd_q[p][wr_ptr_q[p]] <= cap_cmd_q[p];
            mem_op1_q[p][wr_ptr_q[p]] <= cap_op1_q[p];
            mem_op2_q[p][wr_ptr_q[p]] <= req_data_in[p*DATA_W +: DATA_W];
            mem_tag_q[p][wr_ptr_q[p]] <= cap_tag_q[p];
         end
      end
   end

   always_comb begin
      rej_resp   = '0;
      rej_tag    = '0;
      fifo_level = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         rej_resp[p*2 +: 2]        = rej_resp_q[p];
         rej_tag[p*TAG_W +: TAG_W] = rej_tag_q[p];
         fifo_level[p*LvlW +: LvlW] = level_q[p];
      end
   end

   assign eng_valid = eng_valid_q;
   assign eng_cmd   = eng_cmd_q;
   assign eng_op1   = eng_op1_q;
   assign eng_op2   = eng_op2_q;
   assign eng_tag   = eng_tag_q;
   assign eng_port  = eng_port_q;

endmodule

// File: tb/tb_calc_req_arbiter.sv
// tb_calc_req_arbiter
//   Directed bench for calc_req_arbiter with the default parameters (4 ports,
//   4-bit cmd, 32-bit data, 2-bit tag, depth 4). Inputs change 1 time unit after
//   the rising edge. Outputs are sampled at the same point, so each tick()
//   enters the next cycle and shows the registers updated at that edge.
module tb_calc_req_arbiter;

   logic        clk;
   logic        reset;
   logic [15:0] req_cmd_in;
   logic [127:0] req_data_in;
   logic [7:0]  req_tag_in;
   logic [7:0]  rej_resp;
   logic [7:0]  rej_tag;
   logic        eng_valid;
   logic        eng_ready;
   logic [3:0]  eng_cmd;
   logic [31:0] eng_op1;
   logic [31:0] eng_op2;
   logic [1:0]  eng_tag;
   logic [1:0]  eng_port;
   logic [11:0] fifo_level;

   logic [3:0]  cmd_a  [4];
   logic [31:0] data_a [4];
   logic [1:0]  tag_a  [4];

   int n_checks = 0;
   int n_fail   = 0;

   calc_req_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_tag_in  (req_tag_in),
      .rej_resp    (rej_resp),
      .rej_tag     (rej_tag),
      .eng_valid   (eng_valid),
      .eng_ready   (eng_ready),
      .eng_cmd     (eng_cmd),
      .eng_op1     (eng_op1),
      .eng_op2     (eng_op2),
      .eng_tag     (eng_tag),
      .eng_port    (eng_port),
      .fifo_level  (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_cmd_in  = '0;
      req_data_in = '0;
      req_tag_in  = '0;
      for (int p = 0; p < 4; p++) begin
         req_cmd_in[p*4 +: 4]   = cmd_a[p];
         req_data_in[p*32 +: 32] = data_a[p];
         req_tag_in[p*2 +: 2]   = tag_a[p];
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d,
                           input logic [1:0] t);
      cmd_a[p]  = c;
      data_a[p] = d;
      tag_a[p]  = t;
   endtask

   task automatic clear_inputs();
      for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'd0, 2'd0);
   endtask

   function automatic logic [2:0] lvl(input int p);
      return fifo_level[p*3 +: 3];
   endfunction

   // Leaves the bench at the start of "cycle 0" with reset released.
   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_grant(input string tag, input logic [1:0] port, input logic [3:0] c,
                              input logic [31:0] o1, input logic [31:0] o2,
                              input logic [1:0] t);
      check_eq({tag, ".valid"}, 64'(eng_valid), 64'd1);
      check_eq({tag, ".port"}, 64'(eng_port), 64'(port));
      check_eq({tag, ".cmd"}, 64'(eng_cmd), 64'(c));
      check_eq({tag, ".op1"}, 64'(eng_op1), 64'(o1));
      check_eq({tag, ".op2"}, 64'(eng_op2), 64'(o2));
      check_eq({tag, ".tag"}, 64'(eng_tag), 64'(t));
   endtask

   initial begin
      eng_ready = 1'b1;
      reset     = 1'b0;
      clear_inputs();

      // Reset state
      do_reset();
      check_eq("rst.valid", 64'(eng_valid), 64'd0);
      check_eq("rst.cmd", 64'(eng_cmd), 64'd0);
      check_eq("rst.op1", 64'(eng_op1), 64'd0);
      check_eq("rst.level", 64'(fifo_level), 64'd0);
      check_eq("rst.rej", 64'({rej_resp, rej_tag}), 64'd0);

      // Single request on port 0: visible in cycle 3 for one cycle
      set_port(0, 4'd1, 32'd5, 2'd2);
      tick();
      set_port(0, 4'd0, 32'd7, 2'd0);
      tick();
      clear_inputs();
      check_eq("t1.c2.valid", 64'(eng_valid), 64'd0);
      check_eq("t1.c2.level0", 64'(lvl(0)), 64'd1);
      tick();
      check_grant("t1.c3", 2'd0, 4'd1, 32'd5, 32'd7, 2'd2);
      check_eq("t1.c3.level0", 64'(lvl(0)), 64'd0);
      tick();
      check_eq("t1.c4.valid", 64'(eng_valid), 64'd0);

      // All four ports at once: grants 0,1,2,3 in cycles 3..6
      do_reset();
      for (int p = 0; p < 4; p++) set_port(p, 4'(p + 1), 32'(10 + p), 2'(p));
      tick();
      for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'(20 + p), 2'd0);
      tick();
      clear_inputs();
      tick();
      for (int p = 0; p < 4; p++) begin
         check_grant($sformatf("t2.g%0d", p), 2'(p), 4'(p + 1), 32'(10 + p), 32'(20 + p),
                     2'(p));
         tick();
      end
      check_eq("t2.c7.valid", 64'(eng_valid), 64'd0);
      check_eq("t2.c7.level", 64'(fifo_level), 64'd0);

      // Back-pressure and overflow on port 2
      do_reset();
      eng_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_port(2, 4'd5, 32'(100 + k), 2'(k));
         tick();
         set_port(2, 4'd0, 32'(200 + k), 2'd0);
         tick();
      end
      clear_inputs();
      // Cycle 12: sixth request dropped at the end of cycle 11
      check_grant("t3.hold", 2'd2, 4'd5, 32'd100, 32'd200, 2'd0);
      check_eq("t3.level2", 64'(lvl(2)), 64'd4);
      check_eq("t3.rej_resp2", 64'(rej_resp[5:4]), 64'd2);
      check_eq("t3.rej_tag2", 64'(rej_tag[5:4]), 64'd1);
      check_eq("t3.rej_other", 64'({rej_resp[7:6], rej_resp[3:0]}), 64'd0);
      tick();
      check_eq("t3.rej_clear", 64'(rej_resp), 64'd0);
      check_eq("t3.rejtag_clear", 64'(rej_tag), 64'd0);
      eng_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         tick();
         check_grant($sformatf("t3.drain%0d", k), 2'd2, 4'd5, 32'(100 + k), 32'(200 + k),
                     2'(k));
      end
      tick();
      check_eq("t3.empty.valid", 64'(eng_valid), 64'd0);
      check_eq("t3.empty.level2", 64'(lvl(2)), 64'd0);

      // Ports 0 and 1 continuously loaded: grants alternate
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (c >= 3) begin
            check_eq($sformatf("t4.c%0d.valid", c), 64'(eng_valid), 64'd1);
            check_eq($sformatf("t4.c%0d.port", c), 64'(eng_port), 64'((c - 3) % 2));
         end
         if (c % 2 == 0) begin
            set_port(0, 4'd2, 32'(300 + c), 2'd0);
            set_port(1, 4'd3, 32'(400 + c), 2'd1);
         end else begin
            set_port(0, 4'd0, 32'd0, 2'd0);
            set_port(1, 4'd0, 32'd0, 2'd0);
         end
         tick();
      end
      clear_inputs();

      // Async reset during port 1's OP2 beat with a held grant
      do_reset();
      eng_ready = 1'b0;
      set_port(0, 4'd1, 32'd1, 2'd0);
      set_port(2, 4'd6, 32'd3, 2'd2);
      tick();
      set_port(0, 4'd0, 32'd2, 2'd0);
      set_port(2, 4'd0, 32'd4, 2'd0);
      tick();
      clear_inputs();
      tick();
      check_eq("t5.c3.valid", 64'(eng_valid), 64'd1);
      set_port(1, 4'd4, 32'd9, 2'd3);
      tick();
      check_eq("t5.c4.level2", 64'(lvl(2)), 64'd1);
      set_port(1, 4'd0, 32'd10, 2'd0);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t5.async.valid", 64'(eng_valid), 64'd0);
      check_eq("t5.async.level", 64'(fifo_level), 64'd0);
      check_eq("t5.async.rej", 64'(rej_resp), 64'd0);
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check_eq($sformatf("t5.post%0d.valid", c), 64'(eng_valid), 64'd0);
         check_eq($sformatf("t5.post%0d.level", c), 64'(fifo_level), 64'd0);
         check_eq($sformatf("t5.post%0d.rej", c), 64'(rej_resp), 64'd0);
      end

      // cmd driven during OP2 is operand data only
      do_reset();
      eng_ready = 1'b1;
      set_port(3, 4'd2, 32'd11, 2'd1);
      tick();
      set_port(3, 4'd3, 32'd22, 2'd3);
      tick();
      clear_inputs();
      tick();
      check_grant("t6.c3", 2'd3, 4'd2, 32'd11, 32'd22, 2'd1);
      for (int c = 4; c < 8; c++) begin
         tick();
         check_eq($sformatf("t6.c%0d.valid", c), 64'(eng_valid), 64'd0);
         check_eq($sformatf("t6.c%0d.level3", c), 64'(lvl(3)), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
